video_timing_meas: RTL
======================

Name: video_timing_meas

Overview:
- Sits directly downstream of the DVI receiver in the pixel-clock domain.
- Consumes decoded hsync/vsync/de plus the channel-valid flag.
- Measures incoming frame geometry (totals, active sizes, sync polarities) and asserts locked once the geometry is stable for LOCK_FRAMES consecutive frames.
- Downstream scalers, line buffers and frame-buffer writers gate on locked and read the geometry outputs.

Parameters:
- CNT_W, 12, width of all pixel and line counters and geometry outputs.
- LOCK_FRAMES, 4, consecutive identical frames required to assert locked (range 1..15).

Ports:
- pix_clk  in  1  recovered pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- data_vld  in  1  all three TMDS channels aligned and valid.
- hsync  in  1  decoded horizontal sync, raw polarity.
- vsync  in  1  decoded vertical sync, raw polarity.
- de  in  1  decoded data enable.
- h_total  out  CNT_W  pixel clocks per line.
- h_active  out  CNT_W  de-high clocks per line.
- v_total  out  CNT_W  lines per frame.
- v_active  out  CNT_W  active lines per frame.
- hs_pol  out  1  1 = hsync active-high.
- vs_pol  out  1  1 = vsync active-high.
- locked  out  1  geometry stable.
- meas_stb  out  1  one-cycle pulse when geometry outputs are updated.
- timing_chg  out  1  one-cycle pulse when locked falls.

Behaviour:
- Reset value of every output is 0.
- Input registering and polarity:
  - hsync/vsync/de are registered once; all edge detection uses the registered and delayed copies.
  - Polarity: sync level sampled while de=1 is the inactive level, so pol = ~sampled level. Sampled on every de rising edge; feeds the normalised syncs (hs_n = hsync ^ ~hs_pol_int, likewise vs_n).
- Line measurement:
  - h_total = clocks between consecutive de rising edges.
  - h_active = clocks de is high within that line.
  - A line with de high for more than one run is recorded as invalid.
- Frame measurement:
  - Frame boundary = rising edge of vs_n.
  - v_total = rising edges of hs_n between frame boundaries.
  - v_active = de rising edges in the frame.
  - h_total/h_active must be identical for every active line of the frame, otherwise the frame is invalid.
- State machine IDLE, ALIGN, MEASURE, LOCKED:
  - IDLE: wait for data_vld=1, then go to ALIGN.
  - ALIGN: discard partial frame; the first frame boundary goes to MEASURE with match_cnt=0.
  - MEASURE, at each frame boundary:
    - Valid frame, equal to the stored reference: match_cnt++; when match_cnt reaches LOCK_FRAMES-1, go to LOCKED.
    - Otherwise: store as new reference, match_cnt=0.
  - LOCKED, at each frame boundary:
    - Identical frame: stay.
    - Different or invalid frame: locked falls, timing_chg pulses, new frame becomes the reference, go to MEASURE.
  - data_vld=0 in any state: go to IDLE next cycle, all counters cleared. If locked was 1, timing_chg pulses and locked=0 that same cycle. Geometry outputs hold their last values.
- Publishing:
  - Geometry outputs and meas_stb update 1 cycle after each frame boundary that closes a valid frame (in MEASURE or LOCKED).
  - Invalid frames never update outputs.
  - locked rises in the same cycle as the meas_stb of the LOCK_FRAMES-th matching frame.
- Invalid frame conditions:
  - Any counter reaching all-ones saturates there and marks the frame invalid; no wrap-around.
  - v_active=0 or h_active=0.
- Simultaneous events: a frame boundary coincident with a de rising edge or hs_n edge counts that edge in the new frame.
- LOCK_FRAMES=1: the first valid frame after ALIGN locks.
- reset mid-frame: IDLE next cycle; locked=0 with no timing_chg pulse.

Decomposition:
- Package vtm_pkg: state enum (IDLE/ALIGN/MEASURE/LOCKED), CNT_W default, geometry struct {h_total, h_active, v_total, v_active, hs_pol, vs_pol} used for the reference and comparison.
- Sub-module vtm_sync_norm: input registers, polarity detection, normalised syncs, and one-cycle edge pulses (de_rise, de_fall, hs_rise, vs_rise).

Test Plan:
- 640x480@60 (h_total 800, h_active 640, v_total 525, v_active 480, both syncs active-low), data_vld=1 from start -> first meas_stb after frame 2 boundary with those values, hs_pol=0, vs_pol=0; locked=1 at the 4th matching meas_stb.
- Same stimulus with active-high syncs -> hs_pol=1, vs_pol=1, identical sizes; locked after 4 frames.
- Locked 640x480, switch to 800x600 (1056/800/628/600) -> timing_chg pulse and locked=0 at the first changed boundary; new values on meas_stb; relock after 4 more frames.
- data_vld dropped for 10 clocks mid-frame while locked -> timing_chg same cycle, locked=0, outputs hold; relock 5 frame boundaries after recovery (1 ALIGN + 4 matching).
- One line of a frame with h_active 639 -> no meas_stb for that frame, match_cnt restarts, lock delayed accordingly.
- CNT_W=8 with h_total 800 -> counter saturates at 255, no meas_stb ever, locked stays 0.

Source files
------------

// File: rtl/vtm_pkg.sv
// rtl/vtm_pkg.sv - shared types and constants for video timing measurement
package vtm_pkg;

    // Default counter width and lock depth.
    localparam int CNT_W_DEF       = 12;
    localparam int LOCK_FRAMES_DEF = 4;

    // Geometry fields are held at a fixed width so the reference register and
    // its comparison do not depend on the counter width (CNT_W must be <= GEOM_W).
    localparam int GEOM_W  = 16;
    localparam int MATCH_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_MEASURE,
        ST_LOCKED
    } vtm_state_e;

    typedef struct packed {
        logic [GEOM_W-1:0] h_total;
        logic [GEOM_W-1:0] h_active;
        logic [GEOM_W-1:0] v_total;
        logic [GEOM_W-1:0] v_active;
        logic              hs_pol;
        logic              vs_pol;
    } vtm_geom_t;

    // Matching-frame counter saturates instead of wrapping back to zero.
    function automatic logic [MATCH_W-1:0] match_inc(input logic [MATCH_W-1:0] m);
        return (m == '1) ? m : m + 1'b1;
    endfunction

endpackage

// File: rtl/vtm_sync_norm.sv
// rtl/vtm_sync_norm.sv - input registers, sync polarity detection and edge pulses
module vtm_sync_norm
    import vtm_pkg::*;
(
    input  logic pix_clk,
    input  logic reset,
    input  logic hsync,
    input  logic vsync,
    input  logic de,
    output logic hs_pol_int,
    output logic vs_pol_int,
    output logic de_lvl,
    output logic de_rise,
    output logic de_fall,
    output logic hs_rise,
    output logic vs_rise
);

    logic hs_q;
    logic vs_q;
    logic de_q;
    logic de_dly_q;
    logic hs_pol_q;
    logic vs_pol_q;
    logic hs_n_dly_q;
    logic vs_n_dly_q;
    logic hs_n;
    logic vs_n;

    // Normalised syncs are high while the sync pulse is active.
    assign hs_n = hs_q ^ ~hs_pol_q;
    assign vs_n = vs_q ^ ~vs_pol_q;

    assign de_lvl     = de_q;
    assign de_rise    = de_q & ~de_dly_q;
    assign de_fall    = ~de_q & de_dly_q;
    assign hs_rise    = hs_n & ~hs_n_dly_q;
    assign vs_rise    = vs_n & ~vs_n_dly_q;
    assign hs_pol_int = hs_pol_q;
    assign vs_pol_int = vs_pol_q;

    // Register inputs, keep delayed copies for edges, learn polarity at each de rise.
    // Delayed normalised syncs reset high so leaving reset never fakes a sync edge.
    always_ff @(posedge pix_clk) begin
        if (reset) begin
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            de_q       <= 1'b0;
            de_dly_q   <= 1'b0;
            hs_pol_q   <= 1'b0;
            vs_pol_q   <= 1'b0;
            hs_n_dly_q <= 1'b1;
            vs_n_dly_q <= 1'b1;
        end else begin
            hs_q       <= hsync;
            vs_q       <= vsync;
            de_q       <= de;
            de_dly_q   <= de_q;
            hs_n_dly_q <= hs_n;
            vs_n_dly_q <= vs_n;
            if (de_rise) begin
                hs_pol_q <= ~hs_q;
                vs_pol_q <= ~vs_q;
            end
        end
    end

endmodule

// File: rtl/video_timing_meas.sv
// rtl/video_timing_meas.sv - frame geometry measurement and lock detection
module video_timing_meas
    import vtm_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
    input  logic             pix_clk,
    input  logic             reset,
    input  logic             data_vld,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             de,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] h_active,
    output logic [CNT_W-1:0] v_total,
    output logic [CNT_W-1:0] v_active,
    output logic             hs_pol,
    output logic             vs_pol,
    output logic             locked,
    output logic             meas_stb,
    output logic             timing_chg
);

    localparam logic [CNT_W-1:0]   CNT_MAX = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
    localparam logic [MATCH_W-1:0] LOCK_AT = MATCH_W'(LOCK_FRAMES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    logic hs_pol_int;
    logic vs_pol_int;
    logic de_lvl;
    logic de_rise;
    logic de_fall;
    logic hs_rise;
    logic vs_rise;

    vtm_sync_norm u_sync_norm (
        .pix_clk    (pix_clk),
        .reset      (reset),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .hs_pol_int (hs_pol_int),
        .vs_pol_int (vs_pol_int),
        .de_lvl     (de_lvl),
        .de_rise    (de_rise),
        .de_fall    (de_fall),
        .hs_rise    (hs_rise),
        .vs_rise    (vs_rise)
    );

    // Line-level counters and per-frame accumulators.
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic [CNT_W-1:0] va_cnt_q, va_cnt_d;
    logic [CNT_W-1:0] ht_q, ht_d;
    logic [CNT_W-1:0] ha_q, ha_d;
    logic             have_ht_q, have_ht_d;
    logic             have_ha_q, have_ha_d;
    logic             bad_q, bad_d;
    logic             run_q, run_d;

    // Reference, lock state and published outputs.
    vtm_state_e       state_q;
    vtm_geom_t        ref_q;
    logic             ref_vld_q;
    logic [MATCH_W-1:0] match_q;
    logic [CNT_W-1:0] h_total_q;
    logic [CNT_W-1:0] h_active_q;
    logic [CNT_W-1:0] v_total_q;
    logic [CNT_W-1:0] v_active_q;
    logic             hs_pol_q;
    logic             vs_pol_q;
    logic             locked_q;
    logic             meas_stb_q;
    logic             timing_chg_q;

    vtm_geom_t          cur_geom;
    logic               frame_ok;
    logic               same_ref;
    logic [MATCH_W-1:0] match_nxt;
    logic               lock_now;

    // Next-state of the counters; events coincident with a frame boundary land in the new frame.
    always_comb begin
        h_cnt_d   = de_rise ? CNT_ONE : sat_inc(h_cnt_q);
        a_cnt_d   = de_rise ? CNT_ONE : (de_lvl ? sat_inc(a_cnt_q) : a_cnt_q);
        run_d     = hs_rise ? 1'b0 : run_q;
        v_cnt_d   = vs_rise ? '0 : v_cnt_q;
        va_cnt_d  = vs_rise ? '0 : va_cnt_q;
        have_ht_d = vs_rise ? 1'b0 : have_ht_q;
        have_ha_d = vs_rise ? 1'b0 : have_ha_q;
        bad_d     = vs_rise ? 1'b0 : bad_q;
        ht_d      = ht_q;
        ha_d      = ha_q;

        if (hs_rise) begin
            v_cnt_d = sat_inc(v_cnt_d);
        end

        if (de_rise) begin
            // A second de run inside one hsync period makes the line unusable.
            if (run_d) begin
                bad_d = 1'b1;
            end
            run_d = 1'b1;
            // Line length is only known when the previous de rise was in this frame.
            if (va_cnt_d != '0) begin
                if ((h_cnt_q == CNT_MAX) || (have_ht_d && (h_cnt_q != ht_d))) begin
                    bad_d = 1'b1;
                end
                if (!have_ht_d) begin
                    ht_d      = h_cnt_q;
                    have_ht_d = 1'b1;
                end
            end
            va_cnt_d = sat_inc(va_cnt_d);
        end

        if (de_fall) begin
            if ((a_cnt_q == CNT_MAX) || (have_ha_d && (a_cnt_q != ha_d))) begin
                bad_d = 1'b1;
            end
            if (!have_ha_d) begin
                ha_d      = a_cnt_q;
                have_ha_d = 1'b1;
            end
        end

        if (!data_vld) begin
            h_cnt_d   = '0;
            a_cnt_d   = '0;
            v_cnt_d   = '0;
            va_cnt_d  = '0;
            ht_d      = '0;
            ha_d      = '0;
            have_ht_d = 1'b0;
            have_ha_d = 1'b0;
            bad_d     = 1'b0;
            run_d     = 1'b0;
        end
    end

    // Counter and accumulator registers.
    always_ff @(posedge pix_clk) begin
        if (reset) begin
            h_cnt_q   <= '0;
            a_cnt_q   <= '0;
            v_cnt_q   <= '0;
            va_cnt_q  <= '0;
            ht_q      <= '0;
            ha_q      <= '0;
            have_ht_q <= 1'b0;
            have_ha_q <= 1'b0;
            bad_q     <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            a_cnt_q   <= a_cnt_d;
            v_cnt_q   <= v_cnt_d;
            va_cnt_q  <= va_cnt_d;
            ht_q      <= ht_d;
            ha_q      <= ha_d;
            have_ht_q <= have_ht_d;
            have_ha_q <= have_ha_d;
            bad_q     <= bad_d;
            run_q     <= run_d;
        end
    end

    // Geometry of the frame being closed and its comparison with the reference.
    always_comb begin
        cur_geom.h_total  = GEOM_W'(ht_q);
        cur_geom.h_active = GEOM_W'(ha_q);
        cur_geom.v_total  = GEOM_W'(v_cnt_q);
        cur_geom.v_active = GEOM_W'(va_cnt_q);
        cur_geom.hs_pol   = hs_pol_int;
        cur_geom.vs_pol   = vs_pol_int;
        frame_ok  = !bad_q && have_ht_q && have_ha_q && (ha_q != '0) && (va_cnt_q != '0)
                    && (v_cnt_q != CNT_MAX) && (va_cnt_q != CNT_MAX);
        same_ref  = frame_ok && ref_vld_q && (cur_geom == ref_q);
        match_nxt = same_ref ? match_inc(match_q) : '0;
        lock_now  = frame_ok && (match_nxt >= LOCK_AT);
    end

    // Lock state machine with registered geometry, strobe and change outputs.
    always_ff @(posedge pix_clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ref_q        <= '0;
            ref_vld_q    <= 1'b0;
            match_q      <= '0;
            h_total_q    <= '0;
            h_active_q   <= '0;
            v_total_q    <= '0;
            v_active_q   <= '0;
            hs_pol_q     <= 1'b0;
            vs_pol_q     <= 1'b0;
            locked_q     <= 1'b0;
            meas_stb_q   <= 1'b0;
            timing_chg_q <= 1'b0;
        end else begin
            meas_stb_q   <= 1'b0;
            timing_chg_q <= 1'b0;
            if (!data_vld) begin
                state_q      <= ST_IDLE;
                match_q      <= '0;
                ref_vld_q    <= 1'b0;
                locked_q     <= 1'b0;
                timing_chg_q <= locked_q;
            end else begin
                if (vs_rise && frame_ok && ((state_q == ST_MEASURE) || (state_q == ST_LOCKED))) begin
                    h_total_q  <= ht_q;
                    h_active_q <= ha_q;
                    v_total_q  <= v_cnt_q;
                    v_active_q <= va_cnt_q;
                    hs_pol_q   <= hs_pol_int;
                    vs_pol_q   <= vs_pol_int;
                    meas_stb_q <= 1'b1;
                end
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_ALIGN;
                    end
                    ST_ALIGN: begin
                        if (vs_rise) begin
                            state_q   <= ST_MEASURE;
                            match_q   <= '0;
                            ref_vld_q <= 1'b0;
                        end
                    end
                    ST_MEASURE: begin
                        if (vs_rise) begin
                            match_q <= match_nxt;
                            if (!same_ref) begin
                                ref_q     <= cur_geom;
                                ref_vld_q <= frame_ok;
                            end
                            if (lock_now) begin
                                state_q  <= ST_LOCKED;
                                locked_q <= 1'b1;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (vs_rise && !same_ref) begin
                            state_q      <= ST_MEASURE;
                            locked_q     <= 1'b0;
                            timing_chg_q <= 1'b1;
                            match_q      <= '0;
                            ref_q        <= cur_geom;
                            ref_vld_q    <= frame_ok;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign h_total    = h_total_q;
    assign h_active   = h_active_q;
    assign v_total    = v_total_q;
    assign v_active   = v_active_q;
    assign hs_pol     = hs_pol_q;
    assign vs_pol     = vs_pol_q;
    assign locked     = locked_q;
    assign meas_stb   = meas_stb_q;
    assign timing_chg = timing_chg_q;

endmodule
